// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: reads nametable, attribute and both pattern planes for one
// tile row over a req/ack VRAM port and presents planes plus palette select to the shifters.
module bg_tile_fetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] nametable_ptr,
    input  logic [2:0]  pattern_table_offset,
    input  logic        bg_pattern_sel,
    output logic        busy,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        tile_valid,
    output logic [7:0]  tile_lo,
    output logic [7:0]  tile_hi,
    output logic [1:0]  tile_palette
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NT   = 3'd1,
        ST_AT   = 3'd2,
        ST_PLO  = 3'd3,
        ST_PHI  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [2:0]  fine_q, fine_d;
    logic        sel_q, sel_d;
    logic [7:0]  tile_idx_q, tile_idx_d;
    logic [1:0]  pal_cap_q, pal_cap_d;
    logic [7:0]  lo_cap_q, lo_cap_d;
    logic        busy_q, busy_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [7:0]  tile_lo_q, tile_lo_d;
    logic [7:0]  tile_hi_q, tile_hi_d;
    logic [1:0]  tile_pal_q, tile_pal_d;

    function automatic logic [15:0] attr_addr(input logic [15:0] p);
        return 16'h23C0 | (p & 16'h0C00) | ((p >> 4) & 16'h0038) | ((p >> 2) & 16'h0007);
    endfunction

    function automatic logic [15:0] pattern_addr(input logic s, input logic [7:0] t,
                                                 input logic plane, input logic [2:0] f);
        return {3'b000, s, t, plane, f};
    endfunction

    // Quadrant within the 32x32-pixel attribute cell picks which 2-bit field to use.
    function automatic logic [1:0] palette_pick(input logic [7:0] attr, input logic y_hi,
                                                input logic x_hi);
        logic [7:0] shifted;
        shifted = attr >> {y_hi, x_hi, 1'b0};
        return shifted[1:0];
    endfunction

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fine_d     = fine_q;
        sel_d      = sel_q;
        tile_idx_d = tile_idx_q;
        pal_cap_d  = pal_cap_q;
        lo_cap_d   = lo_cap_q;
        tile_lo_d  = tile_lo_q;
        tile_hi_d  = tile_hi_q;
        tile_pal_d = tile_pal_q;
        valid_d    = 1'b0;
        req_d      = 1'b0;
        addr_d     = 16'h0000;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = nametable_ptr;
                    fine_d  = pattern_table_offset;
                    sel_d   = bg_pattern_sel;
                    state_d = ST_NT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NT: begin
                if (mem_rd_ack) begin
                    tile_idx_d = mem_rd_data;
                    state_d    = ST_AT;
                end else begin
                    state_d = ST_NT;
                end
            end
            ST_AT: begin
                if (mem_rd_ack) begin
                    pal_cap_d = palette_pick(mem_rd_data, ptr_q[6], ptr_q[1]);
                    state_d   = ST_PLO;
                end else begin
                    state_d = ST_AT;
                end
            end
            ST_PLO: begin
                if (mem_rd_ack) begin
                    lo_cap_d = mem_rd_data;
                    state_d  = ST_PHI;
                end else begin
                    state_d = ST_PLO;
                end
            end
            ST_PHI: begin
                if (mem_rd_ack) begin
                    tile_lo_d  = lo_cap_q;
                    tile_hi_d  = mem_rd_data;
                    tile_pal_d = pal_cap_q;
                    valid_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_PHI;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Port outputs are registered, so they are decoded from the state being entered.
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_NT: begin
                req_d  = 1'b1;
                addr_d = ptr_d;
            end
            ST_AT: begin
                req_d  = 1'b1;
                addr_d = attr_addr(ptr_d);
            end
            ST_PLO: begin
                req_d  = 1'b1;
                addr_d = pattern_addr(sel_d, tile_idx_d, 1'b0, fine_d);
            end
            ST_PHI: begin
                req_d  = 1'b1;
                addr_d = pattern_addr(sel_d, tile_idx_d, 1'b1, fine_d);
            end
            default: begin
                req_d  = 1'b0;
                addr_d = 16'h0000;
            end
        endcase
    end

    // State, capture and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 16'h0000;
            fine_q     <= 3'd0;
            sel_q      <= 1'b0;
            tile_idx_q <= 8'h00;
            pal_cap_q  <= 2'd0;
            lo_cap_q   <= 8'h00;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 16'h0000;
            valid_q    <= 1'b0;
            tile_lo_q  <= 8'h00;
            tile_hi_q  <= 8'h00;
            tile_pal_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fine_q     <= fine_d;
            sel_q      <= sel_d;
            tile_idx_q <= tile_idx_d;
            pal_cap_q  <= pal_cap_d;
            lo_cap_q   <= lo_cap_d;
            busy_q     <= busy_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            tile_lo_q  <= tile_lo_d;
            tile_hi_q  <= tile_hi_d;
            tile_pal_q <= tile_pal_d;
        end
    end

    assign busy         = busy_q;
    assign mem_rd_req   = req_q;
    assign mem_addr     = addr_q;
    assign tile_valid   = valid_q;
    assign tile_lo      = tile_lo_q;
    assign tile_hi      = tile_hi_q;
    assign tile_palette = tile_pal_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Randomized bench for bg_tile_fetcher: a VRAM responder with wait states and spurious acks,
// checked against a tile-coordinate model of the PPU fetch.
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] nametable_ptr = 16'h0000;
    logic [2:0]  pattern_table_offset = 3'd0;
    logic        bg_pattern_sel = 1'b0;
    logic        busy, mem_rd_req, tile_valid;
    logic [15:0] mem_addr;
    logic        mem_rd_ack = 1'b0;
    logic [7:0]  mem_rd_data = 8'h00;
    logic [7:0]  tile_lo, tile_hi;
    logic [1:0]  tile_palette;

    bg_tile_fetcher dut (
        .clk(clk), .rst(rst), .start(start), .nametable_ptr(nametable_ptr),
        .pattern_table_offset(pattern_table_offset), .bg_pattern_sel(bg_pattern_sel),
        .busy(busy), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .tile_valid(tile_valid),
        .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_palette(tile_palette)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tv_count = 0;
    int busy_falls = 0;
    bit prev_busy = 1'b0;
    logic [7:0]  vram [0:65535];
    logic [15:0] exp_addr [$];
    int dly_mode = 0;        // -1: random 0..2 per request, else fixed wait
    bit spurious = 1'b0;
    int wait_total = 0;
    int wcnt = 0;
    int cur_dly = 0;
    logic [15:0] held_addr = 16'h0000;
    logic [7:0]  last_lo = 8'h00, last_hi = 8'h00;
    logic [1:0]  last_pal = 2'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model of the PPU view: coarse X/Y, nametable quadrant, attribute cell.
    function automatic logic [15:0] m_attr_addr(input logic [15:0] p);
        int cx, cy, nt;
        cx = int'(p) % 32;
        cy = (int'(p) / 32) % 32;
        nt = (int'(p) / 1024) % 4;
        return 16'(32'h23C0 + nt * 32'h400 + (cy / 4) * 8 + cx / 4);
    endfunction

    function automatic logic [1:0] m_pal(input logic [7:0] attr, input logic [15:0] p);
        int cx, cy, quad;
        cx = int'(p) % 32;
        cy = (int'(p) / 32) % 32;
        quad = ((cy % 4) / 2) * 2 + (cx % 4) / 2;
        return 2'((int'(attr) >> (quad * 2)) % 4);
    endfunction

    function automatic logic [15:0] m_pat(input logic s, input logic [7:0] t, input logic [2:0] f);
        return 16'(int'(s) * 4096 + int'(t) * 16 + int'(f));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tile_valid) tv_count++;
        if (prev_busy && !busy) busy_falls++;
        prev_busy = busy;
    end

    // VRAM responder: holds each request for its wait count, then acks with vram data.
    always @(negedge clk) begin
        mem_rd_ack = 1'b0;
        if (mem_rd_req) begin
            if (wcnt == 0) begin
                held_addr = mem_addr;
                cur_dly = (dly_mode < 0) ? int'($urandom_range(0, 2)) : dly_mode;
            end else begin
                check_eq("addr_hold", {16'h0, mem_addr}, {16'h0, held_addr});
            end
            if (wcnt == cur_dly) begin
                mem_rd_ack = 1'b1;
                mem_rd_data = vram[mem_addr];
                if (exp_addr.size() == 0) check_eq("extra_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                else check_eq("addr_order", {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
                wait_total += cur_dly;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spurious && $urandom_range(0, 3) == 0) begin
                mem_rd_ack = 1'b1;
                mem_rd_data = 8'($urandom);
            end
        end
    end

    task automatic push_fetch(input logic [15:0] p, input logic [2:0] f, input logic s);
        logic [15:0] pa;
        pa = m_pat(s, vram[p], f);
        exp_addr.push_back(p);
        exp_addr.push_back(m_attr_addr(p));
        exp_addr.push_back(pa);
        exp_addr.push_back(pa + 16'd8);
        last_lo  = vram[pa];
        last_hi  = vram[pa + 16'd8];
        last_pal = m_pal(vram[m_attr_addr(p)], p);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_lo"}, {24'h0, tile_lo}, {24'h0, last_lo});
        check_eq({tag, "_hi"}, {24'h0, tile_hi}, {24'h0, last_hi});
        check_eq({tag, "_pal"}, {30'h0, tile_palette}, {30'h0, last_pal});
    endtask

    task automatic fetch(input logic [15:0] p, input logic [2:0] f, input logic s, input bit spam);
        int n0, tv0, bf0;
        bit seen;
        push_fetch(p, f, s);
        wait_total = 0;
        tv0 = tv_count;
        bf0 = busy_falls;
        @(negedge clk);
        nametable_ptr = p; pattern_table_offset = f; bg_pattern_sel = s; start = 1'b1;
        @(negedge clk);
        n0 = cyc;
        start = 1'b0;
        check_eq("busy_after_start", {31'h0, busy}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            nametable_ptr = 16'($urandom);
            pattern_table_offset = 3'($urandom);
            bg_pattern_sel = 1'($urandom);
            if (spam) start = 1'($urandom_range(0, 1));
            if (tile_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check_eq("tile_valid_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", cyc + 1 - n0, 5 + wait_total);
            check_eq("busy_in_done", {31'h0, busy}, 32'd1);
            check_outputs("tile");
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("valid_width", {31'h0, tile_valid}, 32'd0);
        @(negedge clk);
        check_eq("idle_busy", {31'h0, busy}, 32'd0);
        check_eq("idle_req", {31'h0, mem_rd_req}, 32'd0);
        check_eq("idle_addr", {16'h0, mem_addr}, 32'd0);
        check_outputs("hold");
        check_eq("one_valid", tv_count - tv0, 32'd1);
        check_eq("one_busy_fall", busy_falls - bf0, 32'd1);
        check_eq("addrs_consumed", exp_addr.size(), 32'd0);
        exp_addr.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check_eq({tag, "_req"}, {31'h0, mem_rd_req}, 32'd0);
        check_eq({tag, "_addr"}, {16'h0, mem_addr}, 32'd0);
        check_eq({tag, "_valid"}, {31'h0, tile_valid}, 32'd0);
        check_eq({tag, "_lo"}, {24'h0, tile_lo}, 32'd0);
        check_eq({tag, "_hi"}, {24'h0, tile_hi}, 32'd0);
        check_eq({tag, "_pal"}, {30'h0, tile_palette}, 32'd0);
    endtask

    initial begin
        int tv_cyc [3];
        int nseen, tv0;
        for (int a = 0; a < 65536; a++) vram[a] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Basic fetch
        vram[16'h2000] = 8'h41; vram[16'h23C0] = 8'hE4;
        vram[16'h0410] = 8'h55; vram[16'h0418] = 8'hAA;
        fetch(16'h2000, 3'd0, 1'b0, 1'b0);
        check_eq("basic_lo", {24'h0, tile_lo}, 32'h55);
        check_eq("basic_hi", {24'h0, tile_hi}, 32'hAA);
        check_eq("basic_pal", {30'h0, tile_palette}, 32'd0);

        // Quadrant / palette select
        vram[16'h2C63] = 8'hFF; vram[16'h2FC0] = 8'hE4;
        fetch(16'h2C63, 3'd7, 1'b1, 1'b0);
        check_eq("quad_pal", {30'h0, tile_palette}, 32'd3);

        // Wait states: 3 cycles per request
        dly_mode = 3;
        fetch(16'h2000, 3'd0, 1'b0, 1'b0);
        check_eq("wait_total", wait_total, 32'd12);
        dly_mode = 0;

        // Busy rejection: starts pulsed with other pointers during the fetch and in DONE
        fetch(16'h2000, 3'd0, 1'b0, 1'b1);

        // Reset mid-fetch during PLO
        push_fetch(16'h2C63, 3'd7, 1'b1);
        tv0 = tv_count;
        @(negedge clk);
        nametable_ptr = 16'h2C63; pattern_table_offset = 3'd7; bg_pattern_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("plo_req", {31'h0, mem_rd_req}, 32'd1);
        check_eq("plo_addr", {16'h0, mem_addr}, 32'h1FF7);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("no_valid_on_reset", tv_count - tv0, 32'd0);
        exp_addr.delete();
        last_lo = 8'h00; last_hi = 8'h00; last_pal = 2'd0;
        check_outputs("post_reset");
        fetch(16'h2123, 3'd3, 1'b0, 1'b0);

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++) push_fetch(16'h2A5E, 3'd5, 1'b1);
        @(negedge clk);
        nametable_ptr = 16'h2A5E; pattern_table_offset = 3'd5; bg_pattern_sel = 1'b1; start = 1'b1;
        nseen = 0;
        for (int k = 0; k < 60 && nseen < 3; k++) begin
            @(negedge clk);
            if (tile_valid) begin
                tv_cyc[nseen] = cyc;
                nseen++;
                check_outputs("b2b");
                if (nseen == 3) start = 1'b0;
            end
        end
        check_eq("b2b_count", nseen, 32'd3);
        if (nseen == 3) begin
            check_eq("b2b_gap0", tv_cyc[1] - tv_cyc[0], 32'd6);
            check_eq("b2b_gap1", tv_cyc[2] - tv_cyc[1], 32'd6);
        end
        repeat (3) @(negedge clk);
        check_eq("b2b_idle", {31'h0, busy}, 32'd0);
        check_eq("b2b_addrs", exp_addr.size(), 32'd0);
        exp_addr.delete();

        // Randomized fetches with random wait states, spurious acks and busy starts
        dly_mode = -1;
        spurious = 1'b1;
        for (int n = 0; n < 25; n++) begin
            fetch(16'h2000 + 16'($urandom_range(0, 16'h0FFF)), 3'($urandom),
                  1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_outputs("rand_hold");
        end
        spurious = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
